// File: rtl/alu_sched_pkg.sv
// Shared opcode constants, FSM encoding and opcode helpers for the ALU scheduler.
package alu_sched_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_NOT;
   endfunction

   // Only the arithmetic opcodes update the ALU carry; logic ops leave it stale.
   function automatic logic op_has_cout(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, shared-ALU and response signals of the ALU scheduler.
interface alu_scheduler_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [1:0]        Req_Valid;
   logic [1:0]        Req_Ready;
   logic [DATA_W-1:0] Req0_A, Req0_B, Req1_A, Req1_B;
   logic [2:0]        Req0_Op, Req1_Op;
   logic [DATA_W-1:0] Alu_A, Alu_B;
   logic [2:0]        Alu_Opcode;
   logic              Alu_Enable;
   logic [DATA_W-1:0] Alu_Result;
   logic              Alu_Cout;
   logic              Rsp_Valid, Rsp_Ready, Rsp_Id;
   logic [DATA_W-1:0] Rsp_Result;
   logic              Rsp_Cout, Rsp_Err;
   logic [CNT_W-1:0]  Op_Count;

   modport slave (
      input  Req_Valid, Req0_A, Req0_B, Req1_A, Req1_B, Req0_Op, Req1_Op,
      input  Alu_Result, Alu_Cout, Rsp_Ready,
      output Req_Ready, Alu_A, Alu_B, Alu_Opcode, Alu_Enable,
      output Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Cout, Rsp_Err, Op_Count
   );

   modport master (
      output Req_Valid, Req0_A, Req0_B, Req1_A, Req1_B, Req0_Op, Req1_Op,
      output Alu_Result, Alu_Cout, Rsp_Ready,
      input  Req_Ready, Alu_A, Alu_B, Alu_Opcode, Alu_Enable,
      input  Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Cout, Rsp_Err, Op_Count
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is taken.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic prio_q, prio_d;  // index that wins a tie

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
      prio_d = prio_q;
      if (advance) prio_d = gnt[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end
endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto one registered ALU_32bit and returns one
// response at a time; the ALU clock enable is a single-cycle registered pulse.
module alu_scheduler #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input logic            Clk,
   input logic            Rst_n,
   alu_scheduler_if.slave bus
);
   import alu_sched_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]        alu_op_q, alu_op_d;
   logic              alu_en_q, alu_en_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_cout_q, rsp_cout_d;
   logic              rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;

   logic [1:0]        gnt, ready;
   logic              req_hs, sel;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic [2:0]        sel_op;

   rr_arbiter2 u_arb (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .req     (bus.Req_Valid),
      .advance (req_hs),
      .gnt     (gnt)
   );

   assign ready  = ((state_q == S_IDLE) && Rst_n) ? gnt : 2'b00;
   assign req_hs = |(bus.Req_Valid & ready);
   assign sel    = ready[1];
   assign sel_a  = sel ? bus.Req1_A  : bus.Req0_A;
   assign sel_b  = sel ? bus.Req1_B  : bus.Req0_B;
   assign sel_op = sel ? bus.Req1_Op : bus.Req0_Op;

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      alu_en_d     = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_cout_d   = rsp_cout_q;
      rsp_err_d    = rsp_err_q;
      op_cnt_d     = op_cnt_q;
      if (state_q == S_ISSUE && op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_ONE;

      case (state_q)
         S_IDLE: begin
            if (req_hs) begin
               rsp_id_d = sel;
               if (op_legal(sel_op)) begin
                  alu_a_d  = sel_a;
                  alu_b_d  = sel_b;
                  alu_op_d = sel_op;
                  alu_en_d = 1'b1;
                  state_d  = S_ISSUE;
               end else begin
                  rsp_result_d = '0;
                  rsp_cout_d   = 1'b0;
                  rsp_err_d    = 1'b1;
                  state_d      = S_RESPOND;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            rsp_result_d = bus.Alu_Result;
            rsp_cout_d   = op_has_cout(alu_op_q) & bus.Alu_Cout;
            rsp_err_d    = 1'b0;
            state_d      = S_RESPOND;
         end
         S_RESPOND: begin
            // Valid trails entry into RESPOND by a cycle so the payload is settled first.
            if (rsp_valid_q && bus.Rsp_Ready) state_d = S_IDLE;
            else                              rsp_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q      <= S_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_en_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         op_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         alu_en_q     <= alu_en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_cout_q   <= rsp_cout_d;
         rsp_err_q    <= rsp_err_d;
         op_cnt_q     <= op_cnt_d;
      end
   end

   assign bus.Req_Ready  = ready;
   assign bus.Alu_A      = alu_a_q;
   assign bus.Alu_B      = alu_b_q;
   assign bus.Alu_Opcode = alu_op_q;
   assign bus.Alu_Enable = alu_en_q;
   assign bus.Rsp_Valid  = rsp_valid_q;
   assign bus.Rsp_Id     = rsp_id_q;
   assign bus.Rsp_Result = rsp_result_q;
   assign bus.Rsp_Cout   = rsp_cout_q;
   assign bus.Rsp_Err    = rsp_err_q;
   assign bus.Op_Count   = op_cnt_q;
endmodule
